// File: rtl/rat_path_player.sv
// rat_path_player: records the rat's move stream in a LIFO and replays the final path as X/Y steps.
// Optional build macro PLAY_PACE_EN: pace playback to one step every STEP_CYCLES clocks.
module rat_path_player #(
   parameter int DEPTH       = 256,
   parameter int AW          = 8,
   parameter int START_X     = 0,
   parameter int START_Y     = 0,
   parameter int STEP_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Push,
   input  logic       Pop,
   input  logic [1:0] Move,
   input  logic       Done,
   input  logic       Fail,
   input  logic       Run,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       PosValid,
   output logic       Busy,
   output logic       Finished,
   output logic       NoPath,
   output logic       Overflow
);
   typedef enum logic [2:0] {REC, READY, PLAY, FINISH, FAILED} state_t;
   localparam logic [3:0] SX = 4'(START_X);
   localparam logic [3:0] SY = 4'(START_Y);
   state_t          state_q;
   logic [1:0]      mem_q [DEPTH];
   logic [AW:0]     count_q, cnt_m1;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_addr;
   logic [1:0]      rd_q;
   logic [3:0]      x_q, y_q, nx, ny;
   logic            pv_q, ovf_q, full, wr_en, start, step, last, pace_done;
`ifdef PLAY_PACE_EN
   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   logic [PW-1:0] pace_q;
   assign pace_done = pace_q == PW'(STEP_CYCLES - 1);
   // pace counter: restarts on playback entry and after every emitted step
   always_ff @(posedge CLK) begin
      if (RST || start || step) pace_q <= '0;
      else if (state_q == PLAY) pace_q <= pace_q + 1'b1;
   end
`else
   assign pace_done = 1'b1;
`endif
   // next read address, write port decode and the coordinate update for the entry being replayed
   always_comb begin
      full     = count_q[AW];
      cnt_m1   = count_q - 1'b1;
      start    = Run && (state_q == READY || state_q == FINISH);
      step     = state_q == PLAY && pace_done;
      last     = {1'b0, rd_ptr_q} == cnt_m1;
      rd_ptr_d = start ? '0 : step ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_en    = state_q == REC && Push && (!full || Pop);
      wr_addr  = (Pop && count_q != '0) ? cnt_m1[AW-1:0] : count_q[AW-1:0];
      nx       = rd_q == 2'b01 ? x_q + 4'd1 : rd_q == 2'b11 ? x_q - 4'd1 : x_q;
      ny       = rd_q == 2'b10 ? y_q + 4'd1 : rd_q == 2'b00 ? y_q - 4'd1 : y_q;
   end
   // move store: one write port, registered read tracking the next pointer so steps run back-to-back
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_addr] <= Move;
      rd_q <= mem_q[rd_ptr_d];
   end
   // control FSM: record, wait for Run, replay, hold result or report failure
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= REC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         x_q      <= SX;
         y_q      <= SY;
         pv_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         pv_q     <= 1'b0;
         rd_ptr_q <= rd_ptr_d;
         case (state_q)
            REC: begin
               if (Push && Pop) begin
                  if (count_q == '0) count_q <= count_q + 1'b1;
               end else if (Push) begin
                  if (full) ovf_q <= 1'b1;
                  else count_q <= count_q + 1'b1;
               end else if (Pop && count_q != '0) begin
                  count_q <= cnt_m1;
               end
               if (Fail) state_q <= FAILED;
               else if (Done) state_q <= READY;
            end
            READY, FINISH: begin
               if (Run) begin
                  state_q <= count_q == '0 ? FINISH : PLAY;
                  x_q     <= SX;
                  y_q     <= SY;
                  pv_q    <= 1'b1;
               end
            end
            PLAY: begin
               if (step) begin
                  x_q  <= nx;
                  y_q  <= ny;
                  pv_q <= 1'b1;
                  if (last) state_q <= FINISH;
               end
            end
            default: ;
         endcase
      end
   end
   assign X        = x_q;
   assign Y        = y_q;
   assign PosValid = pv_q;
   assign Overflow = ovf_q;
   assign Busy     = state_q == PLAY;
   assign Finished = state_q == FINISH;
   assign NoPath   = state_q == FAILED;
endmodule

// File: tb/tb_rat_path_player.sv
// tb_rat_path_player: table, random and corner-case checks of rat_path_player against a stack/path model.
module tb_rat_path_player;
   localparam int DEPTH = 256;
   localparam int SX = 0;
   localparam int SY = 0;
`ifdef PLAY_PACE_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 1;
`endif
   logic clk = 0, rst, push, pop, done, fail, run;
   logic [1:0] move;
   logic [3:0] x, y;
   logic pv, busy, fin, nopath, ovf;
   int checks = 0, errors = 0;
   logic [1:0] stk[$];
   logic [7:0] got[$], expq[$];
   int gaps_bad;
   bit seen_fin;

   typedef struct {
      int          n;
      logic [23:0] ops;
      int          len;
      int          ex;
      int          ey;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   rat_path_player #(.DEPTH(DEPTH), .AW(8), .START_X(SX), .START_Y(SY), .STEP_CYCLES(4)) dut (
      .CLK(clk), .RST(rst), .Push(push), .Pop(pop), .Move(move), .Done(done), .Fail(fail), .Run(run),
      .X(x), .Y(y), .PosValid(pv), .Busy(busy), .Finished(fin), .NoPath(nopath), .Overflow(ovf));

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1; push = 0; pop = 0; done = 0; fail = 0; run = 0; move = 0;
      tick;
      rst = 0;
      stk.delete();
   endtask

   // op: bit2 = push, bit3 = pop, bits1:0 = move
   task automatic apply_op(input logic [3:0] op);
      push = op[2]; pop = op[3]; move = op[1:0];
      case (op[3:2])
         2'b01: if (stk.size() < DEPTH) stk.push_back(op[1:0]);
         2'b10: if (stk.size() > 0) void'(stk.pop_back());
         2'b11: if (stk.size() == 0) stk.push_back(op[1:0]); else stk[stk.size()-1] = op[1:0];
         default: ;
      endcase
      tick;
      push = 0; pop = 0;
   endtask

   task automatic pulse_done;
      done = 1;
      tick;
      done = 0;
   endtask

   task automatic build_exp;
      logic [3:0] cx, cy;
      cx = 4'(SX); cy = 4'(SY);
      expq.delete();
      expq.push_back({cx, cy});
      foreach (stk[i]) begin
         case (stk[i])
            2'd0: cy = cy - 4'd1;
            2'd1: cx = cx + 4'd1;
            2'd2: cy = cy + 4'd1;
            default: cx = cx - 4'd1;
         endcase
         expq.push_back({cx, cy});
      end
   endtask

   task automatic play(input string tag);
      int last;
      run = 1;
      tick;
      run = 0;
      got.delete();
      gaps_bad = 0;
      seen_fin = 0;
      last = 0;
      for (int c = 0; c < 3000; c++) begin
         if (pv) begin
            if (got.size() > 0 && c - last != GAP) gaps_bad++;
            got.push_back({x, y});
            last = c;
         end
         if (fin) begin
            seen_fin = 1;
            break;
         end
         tick;
      end
      chk({tag, " finished"}, int'(seen_fin), 1);
      chk({tag, " length"}, got.size(), expq.size());
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         chk($sformatf("%s step%0d xy", tag, i), int'(got[i]), int'(expq[i]));
      chk({tag, " spacing"}, gaps_bad, 0);
      chk({tag, " busy end"}, int'(busy), 0);
      chk({tag, " final xy"}, int'({x, y}), int'(expq[expq.size()-1]));
   endtask

   initial begin
      int n, r, pvc;
      tbl[0] = '{4, 24'h5566,   5, 2, 2};
      tbl[1] = '{6, 24'h566885, 3, 2, 0};
      tbl[2] = '{2, 24'h5E,     2, 0, 1};
      tbl[3] = '{1, 24'h7,      2, 15, 0};
      tbl[4] = '{1, 24'h4,      2, 0, 15};
      tbl[5] = '{0, 24'h0,      1, 0, 0};
      tbl[6] = '{2, 24'h86,     2, 0, 1};
      tbl[7] = '{1, 24'hD,      2, 1, 0};

      do_reset;
      chk("reset xy", int'({x, y}), 0);
      chk("reset flags", int'({pv, busy, fin, nopath, ovf}), 0);

      foreach (tbl[k]) begin
         do_reset;
         for (int i = 0; i < tbl[k].n; i++) apply_op(tbl[k].ops[4*(tbl[k].n-1-i) +: 4]);
         pulse_done;
         build_exp;
         play($sformatf("tbl%0d", k));
         chk($sformatf("tbl%0d table length", k), got.size(), tbl[k].len);
         chk($sformatf("tbl%0d table x", k), int'(x), tbl[k].ex);
         chk($sformatf("tbl%0d table y", k), int'(y), tbl[k].ey);
      end

      for (int t = 0; t < 20; t++) begin
         do_reset;
         n = $urandom_range(0, 40);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            apply_op({r >= 6, r < 6 || r >= 8, 2'($urandom_range(0, 3))});
         end
         pulse_done;
         build_exp;
         play($sformatf("rnd%0d", t));
         if (t % 4 == 0) play($sformatf("rnd%0d replay", t));
      end

      do_reset;
      for (int i = 0; i < DEPTH; i++) apply_op({2'b01, 2'($urandom_range(0, 3))});
      chk("ovf before full push", int'(ovf), 0);
      apply_op(4'b0101);
      chk("ovf after drop", int'(ovf), 1);
      pulse_done;
      build_exp;
      play("ovf");
      chk("ovf sticky", int'(ovf), 1);

      do_reset;
      apply_op(4'b0101);
      fail = 1;
      tick;
      fail = 0;
      chk("fail nopath", int'(nopath), 1);
      run = 1;
      tick;
      run = 0;
      pvc = 0;
      repeat (6) begin
         if (pv) pvc++;
         tick;
      end
      pulse_done;
      chk("fail no posvalid", pvc, 0);
      chk("fail xy start", int'({x, y}), 0);
      chk("fail stays", int'({nopath, busy, fin}), 3'b100);

      do_reset;
      done = 1; fail = 1;
      tick;
      done = 0; fail = 0;
      chk("done+fail nopath", int'({nopath, fin}), 2'b10);

      do_reset;
      repeat (4) apply_op(4'b0101);
      pulse_done;
      run = 1;
      tick;
      run = 0;
      pvc = 1;
      for (int c = 0; c < 100 && pvc < 3; c++) begin
         tick;
         if (pv) pvc++;
      end
      chk("midplay reached step2", pvc, 3);
      chk("midplay busy", int'(busy), 1);
      rst = 1;
      tick;
      rst = 0;
      stk.delete();
      chk("midplay rst flags", int'({pv, busy, fin, nopath, ovf}), 0);
      chk("midplay rst xy", int'({x, y}), 0);
      pulse_done;
      build_exp;
      play("after rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
